// File: rtl/expande_chave_seq_pkg.sv
// Shared constants, Rcon table, FSM state type and bus-offset helper for the AES-128 key expander.
package expande_chave_seq_pkg;

  localparam int unsigned NUM_RODADAS        = 10;
  localparam int unsigned LARGURA_CHAVE      = 128;
  localparam int unsigned LARGURA_PALAVRA    = 32;
  localparam int unsigned LARGURA_BARRAMENTO = 1280;

  // Element i is Rcon for round key K(i+1).
  localparam logic [NUM_RODADAS-1:0][7:0] RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    EXPANDINDO = 2'd1,
    CONCLUIDO  = 2'd2
  } estado_t;

  // MSB position of word `palavra` of slot `slot` in the row-sliced expanded-key bus.
  function automatic int unsigned msb_palavra(input int unsigned slot, input int unsigned palavra);
    return LARGURA_BARRAMENTO - 1 - (NUM_RODADAS * LARGURA_PALAVRA) * palavra
           - LARGURA_PALAVRA * slot;
  endfunction

endpackage

// File: rtl/expande_chave_seq_if.sv
// Start/key/result bundle between the key-expander client and expande_chave_seq.
interface expande_chave_seq_if;
  import expande_chave_seq_pkg::*;

  logic                          inicio;
  logic [LARGURA_CHAVE-1:0]      chave;
  logic                          ocupado;
  logic                          pronto;
  logic [LARGURA_BARRAMENTO-1:0] chaveExpandida;

  modport master (output inicio, chave, input ocupado, pronto, chaveExpandida);
  modport slave  (input inicio, chave, output ocupado, pronto, chaveExpandida);
endinterface

// File: rtl/expande_chave_seq_sbox_palavra.sv
// Combinational AES SubWord: four forward S-box byte lookups on a 32-bit word.
module sbox_palavra
  import expande_chave_seq_pkg::*;
(
  input  logic [LARGURA_PALAVRA-1:0] i_palavra,
  output logic [LARGURA_PALAVRA-1:0] o_palavra_c
);

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always_comb begin
    o_palavra_c = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      o_palavra_c[8*b +: 8] = SBOX_TAB[2047 - 8 * 32'(i_palavra[8*b +: 8]) -: 8];
    end
  end

endmodule

// File: rtl/expande_chave_seq.sv
// Sequential AES-128 key expander: one round key per clock (word-serial, one word
// per clock, when EXPANDE_SERIAL_EN is defined); result held until the next start.
module expande_chave_seq
  import expande_chave_seq_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  expande_chave_seq_if.slave bus
);

  estado_t                       r_estado, w_prox_estado;
  logic [LARGURA_CHAVE-1:0]      r_chave;
  logic [3:0]                    r_rodada;
  logic [LARGURA_BARRAMENTO-1:0] r_bus;
  logic                          r_ocupado, r_pronto;
  logic                          w_aceita, w_passo_final;
  logic [31:0]                   w_p3, w_rot, w_sub, w_t;

  // Shared g() term: SubWord(RotWord(p3)) ^ Rcon.
  assign w_p3  = r_chave[31:0];
  assign w_rot = {w_p3[23:0], w_p3[31:24]};

  sbox_palavra u_sbox (
    .i_palavra   (w_rot),
    .o_palavra_c (w_sub)
  );

  assign w_t = w_sub ^ {RCON[r_rodada], 24'h0};

`ifdef EXPANDE_SERIAL_EN
  logic [1:0]  r_palavra;
  logic [1:0]  w_palavra_ant;
  logic [31:0] w_p, w_ant, w_nova;

  // Words already rewritten in r_chave this round feed the next word's XOR chain.
  assign w_palavra_ant = r_palavra - 2'd1;
  assign w_p           = r_chave[127 - 32 * 32'(r_palavra) -: 32];
  assign w_ant         = (r_palavra == 2'd0) ? w_t
                                             : r_chave[127 - 32 * 32'(w_palavra_ant) -: 32];
  assign w_nova        = w_p ^ w_ant;
  assign w_passo_final = (r_rodada == 4'(NUM_RODADAS - 1)) && (r_palavra == 2'd3);
`else
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [127:0] w_nova;

  assign w_n0          = r_chave[127:96] ^ w_t;
  assign w_n1          = r_chave[95:64]  ^ w_n0;
  assign w_n2          = r_chave[63:32]  ^ w_n1;
  assign w_n3          = r_chave[31:0]   ^ w_n2;
  assign w_nova        = {w_n0, w_n1, w_n2, w_n3};
  assign w_passo_final = (r_rodada == 4'(NUM_RODADAS - 1));
`endif

  always_ff @(posedge clock) begin
    if (reset) r_estado <= OCIOSO;
    else       r_estado <= w_prox_estado;
  end

  always_comb begin
    w_prox_estado = r_estado;
    w_aceita      = 1'b0;
    unique case (r_estado)
      OCIOSO, CONCLUIDO: begin
        if (bus.inicio) begin
          w_prox_estado = EXPANDINDO;
          w_aceita      = 1'b1;
        end
      end
      EXPANDINDO: begin
        if (w_passo_final) w_prox_estado = CONCLUIDO;
      end
      default: w_prox_estado = OCIOSO;
    endcase
  end

  // Working key, counters, result bus and handshake flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_chave   <= '0;
      r_rodada  <= '0;
      r_bus     <= '0;
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
`ifdef EXPANDE_SERIAL_EN
      r_palavra <= '0;
`endif
    end else begin
      r_ocupado <= (w_prox_estado == EXPANDINDO);
      r_pronto  <= (w_prox_estado == CONCLUIDO);
      if (w_aceita) begin
        r_chave  <= bus.chave;
        r_rodada <= '0;
`ifdef EXPANDE_SERIAL_EN
        r_palavra <= '0;
`endif
      end else if (r_estado == EXPANDINDO) begin
`ifdef EXPANDE_SERIAL_EN
        r_chave[127 - 32 * 32'(r_palavra) -: 32]               <= w_nova;
        r_bus[msb_palavra(32'(r_rodada), 32'(r_palavra)) -: 32] <= w_nova;
        r_palavra <= r_palavra + 2'd1;
        if (r_palavra == 2'd3) r_rodada <= r_rodada + 4'd1;
`else
        r_chave <= w_nova;
        for (int unsigned w = 0; w < 4; w++) begin
          r_bus[msb_palavra(32'(r_rodada), w) -: 32] <= w_nova[127 - 32*w -: 32];
        end
        r_rodada <= r_rodada + 4'd1;
`endif
      end
    end
  end

  assign bus.ocupado        = r_ocupado;
  assign bus.pronto         = r_pronto;
  assign bus.chaveExpandida = r_bus;

endmodule

// File: tb/tb_expande_chave_seq.sv
// Directed and reference-model bench for expande_chave_seq (both builds).
module tb_expande_chave_seq;

`ifdef EXPANDE_SERIAL_EN
  localparam int LAT = 40;
`else
  localparam int LAT = 10;
`endif

  typedef struct {
    logic [127:0] chave;
    logic [127:0] slot0;
    logic [127:0] slot9;
  } vec_t;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic [7:0] sb_tab [256];

  expande_chave_seq_if u_if ();

  expande_chave_seq dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  // S-box derived from the GF(2^8) inverse plus affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [1279:0] modelo(input logic [127:0] k);
    logic [31:0]   p [4];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1279:0] b;
    b  = '0;
    rc = 8'h01;
    for (int w = 0; w < 4; w++) p[w] = k[127 - 32*w -: 32];
    for (int r = 0; r < 10; r++) begin
      t = {sb_tab[p[3][23:16]], sb_tab[p[3][15:8]], sb_tab[p[3][7:0]], sb_tab[p[3][31:24]]}
          ^ {rc, 24'h0};
      p[0] = p[0] ^ t;
      p[1] = p[1] ^ p[0];
      p[2] = p[2] ^ p[1];
      p[3] = p[3] ^ p[2];
      for (int w = 0; w < 4; w++) b[1279 - 320*w - 32*r -: 32] = p[w];
      rc = xtime(rc);
    end
    return b;
  endfunction

  function automatic logic [127:0] slot_de(input logic [1279:0] b, input int r);
    logic [127:0] s;
    for (int w = 0; w < 4; w++) s[127 - 32*w -: 32] = b[1279 - 320*w - 32*r -: 32];
    return s;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nome, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nome, act, exp);
    end
  endtask

  task automatic chk_zero(input string nome);
    n_cmp++;
    if (u_if.chaveExpandida !== '0) begin
      n_err++;
      $display("FAIL %s: got %0d set bits expected 0", nome, $countones(u_if.chaveExpandida));
    end
  endtask

  task automatic chk_bus(input string nome, input logic [127:0] k);
    logic [1279:0] exp;
    logic [1279:0] act;
    bit            ok;
    exp = modelo(k);
    act = u_if.chaveExpandida;
    ok  = 1'b1;
    n_cmp++;
    for (int r = 0; r < 10; r++)
      for (int w = 0; w < 4; w++)
        if (ok && (act[1279 - 320*w - 32*r -: 32] !== exp[1279 - 320*w - 32*r -: 32])) begin
          ok = 1'b0;
          n_err++;
          $display("FAIL %s: slot %0d word %0d got %h expected %h", nome, r, w,
                   act[1279 - 320*w - 32*r -: 32], exp[1279 - 320*w - 32*r -: 32]);
        end
  endtask

  task automatic inicia(input logic [127:0] k);
    u_if.chave  = k;
    u_if.inicio = 1'b1;
    tick();
    u_if.inicio = 1'b0;
  endtask

  // Counts edges after the accepting edge until pronto rises (bounded).
  task automatic espera_pronto(output int n, output int n_ocup);
    n = 0;
    n_ocup = 0;
    while (u_if.pronto !== 1'b1 && n < LAT + 20) begin
      if (u_if.ocupado === 1'b1) n_ocup++;
      tick();
      n++;
    end
  endtask

  localparam logic [127:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] S0_FIPS = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] S9_FIPS = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

  initial begin
    vec_t         tab [3];
    int           n, n_ocup;
    logic [127:0] k, k_nova;

    n_cmp = 0;
    n_err = 0;
    for (int x = 0; x < 256; x++) sb_tab[x] = sbox_calc(8'(x));

    tab[0] = '{chave: K_FIPS, slot0: S0_FIPS, slot9: S9_FIPS};
    tab[1] = '{chave: 128'h0,
               slot0: 128'h62636363_62636363_62636363_62636363,
               slot9: 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e};
    tab[2] = '{chave: 128'h000102030405060708090a0b0c0d0e0f,
               slot0: 128'hd6aa74fd_d2af72fa_daa678f1_d6ab76fe,
               slot9: 128'h13111d7f_e3944a17_f307a78b_4d2b30c5};

    reset       = 1'b1;
    u_if.inicio = 1'b0;
    u_if.chave  = '0;
    tick();
    tick();
    chk("rst_ocupado", 128'(u_if.ocupado), 128'(0));
    chk("rst_pronto", 128'(u_if.pronto), 128'(0));
    chk_zero("rst_bus");
    reset = 1'b0;
    tick();
    chk("pos_rst_ocupado", 128'(u_if.ocupado), 128'(0));
    chk("pos_rst_pronto", 128'(u_if.pronto), 128'(0));
    chk_zero("pos_rst_bus");

    for (int i = 0; i < 3; i++) begin
      inicia(tab[i].chave);
      chk($sformatf("v%0d_aceite_ocupado", i), 128'(u_if.ocupado), 128'(1));
      chk($sformatf("v%0d_aceite_pronto", i), 128'(u_if.pronto), 128'(0));
      espera_pronto(n, n_ocup);
      chk($sformatf("v%0d_latencia", i), 128'(n), 128'(LAT));
      chk($sformatf("v%0d_ciclos_ocupado", i), 128'(n_ocup), 128'(LAT));
      chk($sformatf("v%0d_ocupado_fim", i), 128'(u_if.ocupado), 128'(0));
      chk($sformatf("v%0d_slot0", i), slot_de(u_if.chaveExpandida, 0), tab[i].slot0);
      chk($sformatf("v%0d_slot9", i), slot_de(u_if.chaveExpandida, 9), tab[i].slot9);
      chk_bus($sformatf("v%0d_bus", i), tab[i].chave);
    end

    // inicio held high with the key changed mid-expansion, then restart from CONCLUIDO.
    u_if.chave  = K_FIPS;
    u_if.inicio = 1'b1;
    tick();
    u_if.chave = '1;
    chk("seg_ocupado", 128'(u_if.ocupado), 128'(1));
    espera_pronto(n, n_ocup);
    chk("seg_latencia", 128'(n), 128'(LAT));
    chk("seg_slot0", slot_de(u_if.chaveExpandida, 0), S0_FIPS);
    chk("seg_slot9", slot_de(u_if.chaveExpandida, 9), S9_FIPS);
    tick();
    u_if.inicio = 1'b0;
    chk("reinicio_pronto", 128'(u_if.pronto), 128'(0));
    chk("reinicio_ocupado", 128'(u_if.ocupado), 128'(1));
    espera_pronto(n, n_ocup);
    chk("reinicio_latencia", 128'(n), 128'(LAT));
    chk_bus("reinicio_bus_uns", '1);

    // Reset in the middle of an expansion.
    inicia(K_FIPS);
    for (int i = 0; i < 4; i++) tick();
    chk("meio_ocupado", 128'(u_if.ocupado), 128'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("meio_rst_ocupado", 128'(u_if.ocupado), 128'(0));
    chk("meio_rst_pronto", 128'(u_if.pronto), 128'(0));
    chk_zero("meio_rst_bus");
    tick();
    chk("meio_rst_ocioso", 128'(u_if.ocupado), 128'(0));
    inicia(K_FIPS);
    espera_pronto(n, n_ocup);
    chk("meio_latencia", 128'(n), 128'(LAT));
    chk("meio_slot0", slot_de(u_if.chaveExpandida, 0), S0_FIPS);
    chk_bus("meio_bus", K_FIPS);

    // Back-to-back restarts with random keys.
    k = {$urandom, $urandom, $urandom, $urandom};
    inicia(k);
    for (int i = 0; i < 100; i++) begin
      espera_pronto(n, n_ocup);
      chk($sformatf("b2b%0d_pronto_baixo", i), 128'(n), 128'(LAT));
      chk_bus($sformatf("b2b%0d_bus", i), k);
      k_nova      = {$urandom, $urandom, $urandom, $urandom};
      u_if.chave  = k_nova;
      u_if.inicio = 1'b1;
      tick();
      u_if.inicio = 1'b0;
      k = k_nova;
    end
    espera_pronto(n, n_ocup);
    chk("b2b_final_pronto_baixo", 128'(n), 128'(LAT));
    chk_bus("b2b_final_bus", k);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
